// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with registered read data, occupancy count,
//   almost-full/almost-empty thresholds and one-cycle overflow/underflow
//   pulses.
//
// Ports
//   clk, rstn                 clock (rising edge), async active-low reset
//   wr_en, wr_data            push request and data
//   full, almost_full         count == DEPTH, count >= AF_LEVEL
//   overflow                  pulse the cycle after a push attempted while full
//   rd_en                     pop request
//   rd_data, rd_valid         popped word (1-cycle latency) and its strobe
//   empty, almost_empty       count == 0, count <= AE_LEVEL
//   underflow                 pulse the cycle after a pop attempted while empty
//   count                     current occupancy, 0..DEPTH

module sync_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       almost_empty,
    output logic                       underflow,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] AF_THR = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_THR = (ADDR_W+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Extra MSB on each pointer is the wrap bit: equal addresses with
    // differing wrap bits means the writer is a full lap ahead.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                          (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    // Modular difference of the wrap-extended pointers is exactly 0..DEPTH.
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AF_THR);
    assign almost_empty = (count <= AE_THR);

    // Acceptance uses flags from before the edge: no read-through-write
    // bypass when empty, and a pop while full does not make room for a
    // push in the same cycle.
    assign push_ok = wr_en && !full;
    assign pop_ok  = rd_en && !empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid  <= pop_ok;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_data <= mem[rd_ptr[ADDR_W-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

endmodule
